apu_bus_arbiter: RTL and testbench

Two-requester arbiter sharing the APU register port (12-bit word address, 32-bit data, byte strobes, done/error responses) between the CPU load/store path (requester 0) and the audio DMA engine (requester 1). It sits between the system interconnect and `apu`, and serialises accesses so that exactly one transaction is outstanding on the APU port at any time. It latches the winning request, issues it as a single-cycle strobe, waits for completion (with an optional timeout), and routes the registered response back to the owner.

---
 rtl/apu_bus_arbiter_if.sv | 50 +++++
 rtl/apu_bus_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_apu_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_bus_arbiter_if.sv
// Bus bundle between the system side (CPU load/store + audio DMA requesters,
// APU register port responses) and apu_bus_arbiter.
//   slave  : the arbiter's view (serves requests, drives the APU strobes)
//   master : the surrounding system's view (requesters and the APU itself)
interface apu_bus_arbiter_if;
  // requester side, index 0 = CPU, index 1 = audio DMA
  logic [1:0]        req_write_i;
  logic [1:0]        req_read_i;
  logic [1:0][11:0]  req_address_i;
  logic [1:0][31:0]  req_write_data_i;
  logic [1:0][3:0]   req_write_strobe_i;
  logic [1:0]        req_done_o;
  logic [1:0]        req_error_o;
  logic [1:0][31:0]  req_read_data_o;

  // APU register port
  logic              apu_write_o;
  logic              apu_read_o;
  logic [11:0]       apu_write_address_o;
  logic [11:0]       apu_read_address_o;
  logic [31:0]       apu_write_data_o;
  logic [3:0]        apu_write_strobe_o;
  logic              apu_write_done_i;
  logic              apu_write_error_i;
  logic              apu_read_done_i;
  logic              apu_read_error_i;
  logic [31:0]       apu_read_data_i;

  logic              busy_o;

  modport slave (
    input  req_write_i, req_read_i, req_address_i, req_write_data_i, req_write_strobe_i,
    output req_done_o, req_error_o, req_read_data_o,
    output apu_write_o, apu_read_o, apu_write_address_o, apu_read_address_o,
    output apu_write_data_o, apu_write_strobe_o,
    input  apu_write_done_i, apu_write_error_i, apu_read_done_i, apu_read_error_i,
    input  apu_read_data_i,
    output busy_o
  );

  modport master (
    output req_write_i, req_read_i, req_address_i, req_write_data_i, req_write_strobe_i,
    input  req_done_o, req_error_o, req_read_data_o,
    input  apu_write_o, apu_read_o, apu_write_address_o, apu_read_address_o,
    input  apu_write_data_o, apu_write_strobe_o,
    output apu_write_done_i, apu_write_error_i, apu_read_done_i, apu_read_error_i,
    output apu_read_data_i,
    input  busy_o
  );
endinterface

// File: rtl/apu_bus_arbiter.sv
// Two-requester round-robin arbiter for the APU register port. Keeps exactly
// one access outstanding: latch winner, strobe once, wait for the matching
// response, return a registered done/error/read-data to the owner.
//
// Optional feature macro: APU_ARBITER_TIMEOUT_EN
//   defined     : WAIT is bounded by TIMEOUT_CYCLES, expiry completes with error
//   not defined : WAIT is left only on an APU done/error (no upper bound)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access outstanding; pick a winner and latch its request
// ISSUE   | single-cycle apu_write_o/apu_read_o strobe is on the port
// WAIT    | strobe sent, waiting for matching APU done/error (or timeout)
// RESPOND | done/error pulse to owner, read data loaded, pointer flipped
module apu_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  apu_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic             is_write_q, is_write_d;
  logic [11:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             apu_write_q, apu_write_d;
  logic             apu_read_q, apu_read_d;
  logic [1:0]       req_done_q, req_done_d;
  logic [1:0]       req_error_q, req_error_d;
  logic [1:0][31:0] req_read_data_q, req_read_data_d;

  logic [1:0]       pending;
  logic             win;
  logic             resp_hit;
  logic             resp_err;
  logic             tmo_expire;

  assign pending = bus.req_write_i | bus.req_read_i;

  // Round-robin pick: the pointer's requester wins if it has anything pending.
  always_comb begin
    win = rr_ptr_q;
    if (!pending[rr_ptr_q]) begin
      win = ~rr_ptr_q;
    end
  end

  // Only the response channel matching the issued access type counts.
  always_comb begin
    if (is_write_q) begin
      resp_hit = bus.apu_write_done_i | bus.apu_write_error_i;
      resp_err = bus.apu_write_error_i;
    end else begin
      resp_hit = bus.apu_read_done_i | bus.apu_read_error_i;
      resp_err = bus.apu_read_error_i;
    end
  end

`ifdef APU_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Wait-cycle counter: cleared while issuing, counts each WAIT cycle.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_expire = 1'b0;
    if (state_q == S_ISSUE) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
      tmo_expire = (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES));
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_expire = 1'b0;

  // TIMEOUT_CYCLES has no effect in this build; tie it off visibly.
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    logic finish;
    logic fin_err;

    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    is_write_d      = is_write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    apu_write_d     = 1'b0;
    apu_read_d      = 1'b0;
    req_done_d      = 2'b00;
    req_error_d     = 2'b00;
    req_read_data_d = req_read_data_q;
    finish          = 1'b0;
    fin_err         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|pending) begin
          owner_d     = win;
          // write wins over read for a requester asserting both
          is_write_d  = bus.req_write_i[win];
          addr_d      = bus.req_address_i[win];
          wdata_d     = bus.req_write_data_i[win];
          wstrb_d     = bus.req_write_strobe_i[win];
          apu_write_d = bus.req_write_i[win];
          apu_read_d  = ~bus.req_write_i[win];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (resp_hit) begin
          finish  = 1'b1;
          fin_err = resp_err;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a real response in the expiry cycle takes precedence
        if (resp_hit) begin
          finish  = 1'b1;
          fin_err = resp_err;
        end else if (tmo_expire) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_RESPOND: begin
        rr_ptr_d = ~owner_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response registers load on entry to RESPOND so they line up with it.
    if (finish) begin
      state_d              = S_RESPOND;
      req_done_d[owner_q]  = 1'b1;
      req_error_d[owner_q] = fin_err;
      if (!is_write_q) begin
        req_read_data_d[owner_q] = fin_err ? 32'h0 : bus.apu_read_data_i;
      end
    end
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= 1'b0;
      owner_q         <= 1'b0;
      is_write_q      <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      apu_write_q     <= 1'b0;
      apu_read_q      <= 1'b0;
      req_done_q      <= '0;
      req_error_q     <= '0;
      req_read_data_q <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      is_write_q      <= is_write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      apu_write_q     <= apu_write_d;
      apu_read_q      <= apu_read_d;
      req_done_q      <= req_done_d;
      req_error_q     <= req_error_d;
      req_read_data_q <= req_read_data_d;
    end
  end

  assign bus.apu_write_o         = apu_write_q;
  assign bus.apu_read_o          = apu_read_q;
  assign bus.apu_write_address_o = addr_q;
  assign bus.apu_read_address_o  = addr_q;
  assign bus.apu_write_data_o    = wdata_q;
  assign bus.apu_write_strobe_o  = wstrb_q;
  assign bus.req_done_o          = req_done_q;
  assign bus.req_error_o         = req_error_q;
  assign bus.req_read_data_o     = req_read_data_q;
  assign bus.busy_o              = (state_q != S_IDLE);

endmodule

// File: tb/tb_apu_bus_arbiter.sv
// Directed bench for apu_bus_arbiter. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_apu_bus_arbiter;

  logic clk_i = 1'b0;
  logic rst_n_i;

  always #5 clk_i = ~clk_i;

  apu_bus_arbiter_if bus();

  apu_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  // Simple APU: auto_en answers in the strobe cycle, man_* are driven by hand.
  logic        auto_en, auto_err;
  logic [31:0] auto_rdata, man_rdata;
  logic        man_wdone, man_werr, man_rdone, man_rerr;

  assign bus.apu_write_done_i  = (bus.apu_write_o & auto_en) | man_wdone;
  assign bus.apu_write_error_i = (bus.apu_write_o & auto_en & auto_err) | man_werr;
  assign bus.apu_read_done_i   = (bus.apu_read_o & auto_en) | man_rdone;
  assign bus.apu_read_error_i  = (bus.apu_read_o & auto_en & auto_err) | man_rerr;
  assign bus.apu_read_data_i   = auto_en ? auto_rdata : man_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic set_req(input int idx, input logic wr, input logic rd,
                         input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_write_i[idx]        = wr;
    bus.req_read_i[idx]         = rd;
    bus.req_address_i[idx]      = a;
    bus.req_write_data_i[idx]   = d;
    bus.req_write_strobe_i[idx] = s;
  endtask

  task automatic clr_all();
    set_req(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    auto_en = 1'b0; auto_err = 1'b0; auto_rdata = 32'h0; man_rdata = 32'h0;
    man_wdone = 1'b0; man_werr = 1'b0; man_rdone = 1'b0; man_rerr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    clr_all();
    tick(2);
    rst_n_i = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exp_owner [4];
    logic        exp_wr    [4];
    logic [11:0] exp_addr  [4];
    logic        got, seen_wr;
    logic [11:0] seen_addr;
    logic [31:0] seen_data;
    logic [1:0]  done_seen;

    exp_owner = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_wr    = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_addr  = '{12'h010, 12'h100, 12'h020, 12'h100};

    // ---- reset state
    do_reset();
    check_eq("rst_done",   bus.req_done_o, 2'b00);
    check_eq("rst_error",  bus.req_error_o, 2'b00);
    check_eq("rst_busy",   bus.busy_o, 1'b0);
    check_eq("rst_strobes", {bus.apu_write_o, bus.apu_read_o}, 2'b00);
    check_eq("rst_addr",   bus.apu_write_address_o, 12'h0);
    check_eq("rst_rdata",  bus.req_read_data_o, 64'h0);

    // ---- zero-wait write, requester 0
    auto_en = 1'b1;
    set_req(0, 1'b1, 1'b0, 12'h008, 32'hDEADBEEF, 4'hF);
    tick(1);
    check_eq("w0_strobe", bus.apu_write_o, 1'b1);
    check_eq("w0_rd_strobe", bus.apu_read_o, 1'b0);
    check_eq("w0_data",   bus.apu_write_data_o, 32'hDEADBEEF);
    check_eq("w0_addr",   bus.apu_write_address_o, 12'h008);
    check_eq("w0_strb",   bus.apu_write_strobe_o, 4'hF);
    check_eq("w0_busy",   bus.busy_o, 1'b1);
    tick(1);
    check_eq("w0_done",   bus.req_done_o, 2'b01);
    check_eq("w0_error",  bus.req_error_o, 2'b00);
    check_eq("w0_strobe_off", bus.apu_write_o, 1'b0);
    set_req(0, 1'b0, 1'b0, 12'h008, 32'hDEADBEEF, 4'hF);
    tick(1);
    check_eq("w0_done_off", bus.req_done_o, 2'b00);
    check_eq("w0_idle",   bus.busy_o, 1'b0);
    check_eq("w0_hold_data", bus.apu_write_data_o, 32'hDEADBEEF);

    // ---- contention: both read after reset, requester 0 first
    do_reset();
    auto_en = 1'b1; auto_rdata = 32'h1111_0000;
    set_req(0, 1'b0, 1'b1, 12'h0A0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b1, 12'h0B0, 32'h0, 4'h0);
    tick(1);
    check_eq("ct_rd0_strobe", bus.apu_read_o, 1'b1);
    check_eq("ct_rd0_addr",   bus.apu_read_address_o, 12'h0A0);
    tick(1);
    check_eq("ct_rd0_done",   bus.req_done_o, 2'b01);
    check_eq("ct_rd0_data",   bus.req_read_data_o[0], 32'h1111_0000);
    set_req(0, 1'b0, 1'b0, 12'h0A0, 32'h0, 4'h0);
    auto_rdata = 32'h2222_3333;
    tick(2);
    check_eq("ct_rd1_strobe", bus.apu_read_o, 1'b1);
    check_eq("ct_rd1_addr",   bus.apu_read_address_o, 12'h0B0);
    tick(1);
    check_eq("ct_rd1_done",   bus.req_done_o, 2'b10);
    check_eq("ct_rd1_data",   bus.req_read_data_o[1], 32'h2222_3333);
    check_eq("ct_rd0_held",   bus.req_read_data_o[0], 32'h1111_0000);
    set_req(1, 1'b0, 1'b0, 12'h0B0, 32'h0, 4'h0);
    tick(1);

    // ---- requester 1 read+write, requester 0 interleaved (pointer at 0)
    auto_rdata = 32'h7777_8888;
    set_req(0, 1'b0, 1'b1, 12'h010, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 12'h100, 32'hCAFEF00D, 4'h3);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; seen_wr = 1'b0; seen_addr = 12'h0; seen_data = 32'h0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk_i);
        if (bus.apu_write_o || bus.apu_read_o) begin
          seen_wr   = bus.apu_write_o;
          seen_addr = bus.apu_write_o ? bus.apu_write_address_o : bus.apu_read_address_o;
          seen_data = bus.apu_write_data_o;
        end
        if (bus.req_done_o != 2'b00) got = 1'b1;
      end
      check_eq("rw_owner", bus.req_done_o, exp_owner[k]);
      check_eq("rw_type",  seen_wr, exp_wr[k]);
      check_eq("rw_addr",  seen_addr, exp_addr[k]);
      if (k == 1) check_eq("rw_wdata1", seen_data, 32'hCAFEF00D);
      if (k == 2) check_eq("rw_wdata0", seen_data, 32'h1234_5678);
      case (k)
        0: set_req(0, 1'b1, 1'b0, 12'h020, 32'h1234_5678, 4'hF);
        1: set_req(1, 1'b0, 1'b1, 12'h100, 32'hCAFEF00D, 4'h3);
        2: set_req(0, 1'b0, 1'b0, 12'h020, 32'h0, 4'h0);
        default: set_req(1, 1'b0, 1'b0, 12'h100, 32'h0, 4'h0);
      endcase
    end
    check_eq("rw_rd1_data", bus.req_read_data_o[1], 32'h7777_8888);
    tick(1);

    // ---- APU read error (pointer at 0)
    auto_en = 1'b1; auto_err = 1'b1; auto_rdata = 32'hFFFF_FFFF;
    set_req(0, 1'b0, 1'b1, 12'h030, 32'h0, 4'h0);
    tick(1);
    check_eq("er_strobe", bus.apu_read_o, 1'b1);
    tick(1);
    check_eq("er_done",  bus.req_done_o, 2'b01);
    check_eq("er_error", bus.req_error_o, 2'b01);
    check_eq("er_rdata", bus.req_read_data_o[0], 32'h0);
    set_req(0, 1'b0, 1'b0, 12'h030, 32'h0, 4'h0);
    auto_en = 1'b0; auto_err = 1'b0;
    tick(1);
    check_eq("er_error_off", bus.req_error_o, 2'b00);

    // ---- one wait state, wrong-type response ignored (pointer at 1)
    set_req(1, 1'b0, 1'b1, 12'h040, 32'h0, 4'h0);
    tick(1);
    check_eq("ws_strobe", bus.apu_read_o, 1'b1);
    tick(1);
    check_eq("ws_strobe_off", bus.apu_read_o, 1'b0);
    check_eq("ws_busy",  bus.busy_o, 1'b1);
    check_eq("ws_nodone", bus.req_done_o, 2'b00);
    man_wdone = 1'b1; man_werr = 1'b1;
    tick(1);
    check_eq("ws_wrong_type", bus.req_done_o, 2'b00);
    check_eq("ws_busy2", bus.busy_o, 1'b1);
    man_wdone = 1'b0; man_werr = 1'b0; man_rdone = 1'b1; man_rdata = 32'h5A5A_A5A5;
    tick(1);
    check_eq("ws_done",  bus.req_done_o, 2'b10);
    check_eq("ws_error", bus.req_error_o, 2'b00);
    check_eq("ws_rdata", bus.req_read_data_o[1], 32'h5A5A_A5A5);
    man_rdone = 1'b0;
    set_req(1, 1'b0, 1'b0, 12'h040, 32'h0, 4'h0);
    tick(1);

    // ---- APU never answers (pointer at 0)
    set_req(0, 1'b1, 1'b0, 12'h050, 32'h0BAD_F00D, 4'h5);
    tick(1);
    check_eq("to_strobe", bus.apu_write_o, 1'b1);
    tick(4);
    check_eq("to_wait4_nodone", bus.req_done_o, 2'b00);
    check_eq("to_wait4_busy", bus.busy_o, 1'b1);
    tick(1);
`ifdef APU_ARBITER_TIMEOUT_EN
    check_eq("to_done",  bus.req_done_o, 2'b01);
    check_eq("to_error", bus.req_error_o, 2'b01);
    set_req(0, 1'b0, 1'b0, 12'h050, 32'h0, 4'h0);
    tick(1);
    check_eq("to_idle", bus.busy_o, 1'b0);
    man_wdone = 1'b1;
    tick(1);
    check_eq("to_late_done", bus.req_done_o, 2'b00);
    check_eq("to_late_busy", bus.busy_o, 1'b0);
    man_wdone = 1'b0;
    // get back into WAIT for the reset check
    set_req(1, 1'b0, 1'b1, 12'h060, 32'h0, 4'h0);
    tick(2);
`else
    check_eq("nt_nodone", bus.req_done_o, 2'b00);
    tick(10);
    check_eq("nt_busy", bus.busy_o, 1'b1);
    check_eq("nt_nodone2", bus.req_done_o, 2'b00);
`endif

    // ---- reset mid-WAIT
    check_eq("rw_in_wait", bus.busy_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("ar_busy",   bus.busy_o, 1'b0);
    check_eq("ar_addr",   {bus.apu_write_address_o, bus.apu_read_address_o}, 24'h0);
    check_eq("ar_wdata",  bus.apu_write_data_o, 32'h0);
    check_eq("ar_strb",   bus.apu_write_strobe_o, 4'h0);
    check_eq("ar_rdata",  bus.req_read_data_o, 64'h0);
    check_eq("ar_done",   {bus.req_done_o, bus.req_error_o}, 4'h0);
    clr_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    done_seen = 2'b00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      done_seen = done_seen | bus.req_done_o | bus.req_error_o;
    end
    check_eq("ar_no_pulse", done_seen, 2'b00);
    check_eq("ar_idle",     bus.busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
